// File: rtl/spi_uid_pkg.sv
// Shared constants and types for the UID-query SPI protocol: command/filler
// bytes, responder FSM encoding and the accepted test UIDs.
package spi_uid_pkg;

   localparam logic [7:0]  CMD_UID    = 8'hAA;
   localparam logic [7:0]  FILL_BYTE  = 8'h00;
   localparam int          UID_BYTES  = 4;

   localparam logic [31:0] UID_TEST_A = 32'h332C1EB7;
   localparam logic [31:0] UID_TEST_B = 32'h336BF410;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } uid_state_t;

   // Byte idx of a 32-bit UID, idx 0 = bits 31:24.
   function automatic logic [7:0] uid_byte(input logic [31:0] u, input logic [1:0] idx);
      logic [31:0] s;
      s = u << {idx, 3'b000};
      return s[31:24];
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Brings SCLK/SS/MOSI into the CLOCK_50 domain and derives edge pulses
// from the last synchronizer stage.
module spi_input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic spi_sclk,
   input  logic spi_ss_n,
   input  logic spi_mosi,
   output logic ss_n,
   output logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ss_fall,
   output logic ss_rise
);

   logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
   logic                   sclk_d, ss_d;
   logic                   sclk;

   // Presets match an idle bus (SS high, SCLK low) so release from reset
   // never fabricates an edge.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         sclk_q <= '0;
         ss_q   <= '1;
         mosi_q <= '0;
         sclk_d <= 1'b0;
         ss_d   <= 1'b1;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
         ss_q   <= {ss_q[SYNC_STAGES-2:0], spi_ss_n};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
         sclk_d <= sclk_q[SYNC_STAGES-1];
         ss_d   <= ss_q[SYNC_STAGES-1];
      end
   end

   assign sclk      = sclk_q[SYNC_STAGES-1];
   assign ss_n      = ss_q[SYNC_STAGES-1];
   assign mosi      = mosi_q[SYNC_STAGES-1];
   assign sclk_rise = sclk & ~sclk_d;
   assign sclk_fall = ~sclk & sclk_d;
   assign ss_fall   = ~ss_n & ss_d;
   assign ss_rise   = ss_n & ~ss_d;

endmodule

// File: rtl/spi_uid_responder.sv
// SPI mode-0 slave answering the 0xAA UID query: after the command byte the
// next four bytes return a snapshot of the UID, MSB byte first.
module spi_uid_responder
   import spi_uid_pkg::*;
#(
   parameter logic [7:0] CMD_UID_P   = CMD_UID,
   parameter int         UID_BYTES_P = UID_BYTES,
   parameter logic [7:0] FILL_BYTE_P = FILL_BYTE,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        spi_sclk,
   input  logic        spi_ss_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic [31:0] uid,
   input  logic        uid_valid,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        resp_active,
   output logic        frame_err
);

   logic        ss_s, mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;
   uid_state_t  state;
   logic [2:0]  bit_cnt;
   logic [1:0]  byte_idx;
   logic [7:0]  rx_shift, tx_shift, tx_load;
   logic [31:0] uid_snap;
   logic        byte_done;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .spi_sclk  (spi_sclk),
      .spi_ss_n  (spi_ss_n),
      .spi_mosi  (spi_mosi),
      .ss_n      (ss_s),
      .mosi      (mosi_s),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .ss_fall   (ss_fall),
      .ss_rise   (ss_rise)
   );

   always_comb begin
      tx_load = FILL_BYTE_P;
      if (state == SEND) tx_load = uid_byte(uid_snap, byte_idx);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         byte_idx    <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         uid_snap    <= '0;
         byte_done   <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         resp_active <= 1'b0;
         frame_err   <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
      end else begin
         rx_valid  <= byte_done;
         byte_done <= 1'b0;
         frame_err <= 1'b0;

         // Bit 7 goes out on the SS edge so it is settled before the first SCLK rise.
         if (ss_fall) begin
            bit_cnt     <= '0;
            spi_miso_oe <= 1'b1;
            tx_shift    <= tx_load;
            spi_miso    <= tx_load[7];
         end

         if (!ss_s && sclk_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_data   <= {rx_shift[6:0], mosi_s};
               byte_done <= 1'b1;
            end
         end

         if (!ss_s && sclk_fall && bit_cnt != 3'd0) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            spi_miso <= tx_shift[6];
         end

         if (byte_done) begin
            case (state)
               IDLE: if (rx_data == CMD_UID_P && uid_valid) begin
                  uid_snap    <= uid;
                  byte_idx    <= '0;
                  resp_active <= 1'b1;
                  state       <= SEND;
               end
               SEND: if (byte_idx == 2'(UID_BYTES_P - 1)) begin
                  resp_active <= 1'b0;
                  byte_idx    <= '0;
                  state       <= IDLE;
               end else begin
                  byte_idx <= byte_idx + 2'd1;
               end
               default: state <= IDLE;
            endcase
         end

         // A byte cut short by SS abandons the whole transaction.
         if (ss_rise) begin
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            if (bit_cnt != 3'd0) begin
               frame_err   <= 1'b1;
               bit_cnt     <= '0;
               state       <= IDLE;
               byte_idx    <= '0;
               resp_active <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_uid_responder.sv
// Directed bench: a bit-banged mode-0 master drives the responder while a
// transaction-level protocol model predicts MISO bytes, rx_data and resp_active.
module tb_spi_uid_responder;
   import spi_uid_pkg::*;

   localparam int HALF = 8;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b0;
   logic        spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
   logic [31:0] uid = '0;
   logic        uid_valid = 1'b0;
   logic        spi_miso, spi_miso_oe, rx_valid, resp_active, frame_err;
   logic [7:0]  rx_data;

   spi_uid_responder dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .spi_sclk    (spi_sclk),
      .spi_ss_n    (spi_ss_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .uid         (uid),
      .uid_valid   (uid_valid),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .resp_active (resp_active),
      .frame_err   (frame_err)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int checks = 0, errors = 0;
   int fe_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Protocol model: whether a UID response is in flight, which byte is next,
   // and the UID captured when the command was accepted.
   typedef struct packed {logic [7:0] d; logic r;} exp_t;
   exp_t        q[$];
   exp_t        e;
   bit          m_send = 1'b0;
   int          m_idx = 0;
   logic [31:0] m_snap = '0;

   task automatic model_byte(input logic [7:0] tx);
      if (!m_send) begin
         if (tx == CMD_UID && uid_valid) begin
            m_send = 1'b1; m_snap = uid; m_idx = 0;
         end
      end else begin
         m_idx++;
         if (m_idx == UID_BYTES) begin m_send = 1'b0; m_idx = 0; end
      end
      q.push_back('{tx, m_send});
   endtask

   always @(negedge CLOCK_50) begin
      if (reset) begin
         if (rx_valid) begin
            if (q.size() == 0) chk("rx_unexpected", 32'(rx_valid), 0);
            else begin
               e = q.pop_front();
               chk("rx_data", 32'(rx_data), 32'(e.d));
               chk("resp_active", 32'(resp_active), 32'(e.r));
            end
         end
         if (frame_err) fe_cnt++;
      end
   end

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx_b);
      logic [7:0] exp_miso;
      exp_miso = m_send ? m_snap[8*(3-m_idx) +: 8] : FILL_BYTE;
      spi_ss_n = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      chk("miso_oe_low_ss", 32'(spi_miso_oe), 1);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         repeat (HALF) @(negedge CLOCK_50);
         rx_b[i] = spi_miso;
         spi_sclk = 1'b1;
         if (i == 0) model_byte(tx);
         repeat (HALF) @(negedge CLOCK_50);
         spi_sclk = 1'b0;
      end
      repeat (HALF) @(negedge CLOCK_50);
      spi_ss_n = 1'b1;
      repeat (2*HALF) @(negedge CLOCK_50);
      chk("miso_byte", 32'(rx_b), 32'(exp_miso));
   endtask

   task automatic uid_seq(output logic [7:0] first, output logic [31:0] got);
      logic [7:0] b;
      got = '0;
      xfer(CMD_UID, first);
      for (int k = 0; k < 4; k++) begin
         xfer(8'h00, b);
         got = {got[23:0], b};
      end
   endtask

   task automatic sclk_pulses(input int n);
      for (int k = 0; k < n; k++) begin
         spi_mosi = k[0];
         repeat (HALF) @(negedge CLOCK_50);
         spi_sclk = 1'b1;
         repeat (HALF) @(negedge CLOCK_50);
         spi_sclk = 1'b0;
      end
   endtask

   logic [7:0]  first, b;
   logic [31:0] got;
   int          fe0;

   initial begin
      repeat (4) @(negedge CLOCK_50);
      chk("reset_outs", 32'({spi_miso, spi_miso_oe, rx_data, rx_valid, resp_active, frame_err}), 0);
      reset = 1'b1;
      repeat (4) @(negedge CLOCK_50);

      // 1: valid UID
      uid = UID_TEST_A; uid_valid = 1'b1;
      uid_seq(first, got);
      chk("t1_first", 32'(first), 32'h00);
      chk("t1_uid", got, 32'h332C1EB7);

      // 2: no tag present
      uid_valid = 1'b0;
      uid_seq(first, got);
      chk("t2_uid", got, 32'h0);
      chk("t2_resp", 32'(resp_active), 0);

      // 3: snapshot survives a uid change mid-response
      uid_valid = 1'b1;
      xfer(CMD_UID, first);
      uid = UID_TEST_B;
      got = '0;
      for (int k = 0; k < 4; k++) begin xfer(8'h00, b); got = {got[23:0], b}; end
      chk("t3_snap", got, 32'h332C1EB7);
      uid_seq(first, got);
      chk("t3_new", got, 32'h336BF410);

      // 4: SS aborts response byte 2 after 3 clocks
      uid = UID_TEST_A;
      xfer(CMD_UID, first);
      xfer(8'h00, b);
      chk("t4_byte0", 32'(b), 32'h33);
      fe0 = fe_cnt;
      spi_ss_n = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      sclk_pulses(3);
      repeat (HALF) @(negedge CLOCK_50);
      spi_ss_n = 1'b1;
      repeat (2*HALF) @(negedge CLOCK_50);
      m_send = 1'b0; m_idx = 0;
      chk("t4_frame_err", 32'(fe_cnt - fe0), 1);
      chk("t4_oe", 32'(spi_miso_oe), 0);
      chk("t4_miso", 32'(spi_miso), 0);
      chk("t4_resp", 32'(resp_active), 0);
      uid_seq(first, got);
      chk("t4_uid", got, 32'h332C1EB7);

      // 5: non-command byte ignored
      xfer(8'h55, b);
      chk("t5_b0", 32'(b), 0);
      xfer(8'h00, b);
      chk("t5_b1", 32'(b), 0);
      chk("t5_resp", 32'(resp_active), 0);

      // 6: reset in the middle of response byte 1
      xfer(CMD_UID, first);
      spi_ss_n = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      sclk_pulses(3);
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("t6_reset_outs", 32'({spi_miso, spi_miso_oe, rx_data, rx_valid, resp_active, frame_err}), 0);
      spi_ss_n = 1'b1; spi_sclk = 1'b0;
      repeat (6) @(negedge CLOCK_50);
      m_send = 1'b0; m_idx = 0; q.delete();
      reset = 1'b1;
      repeat (2*HALF) @(negedge CLOCK_50);
      uid_seq(first, got);
      chk("t6_uid", got, 32'h332C1EB7);

      chk("rx_pending", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
